hazard_stall_ctrl: RTL

//  Parametrised pipeline hazard controller for the 5-stage core; sits beside the IF/ID and ID/EX registers.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_perf_cnt.sv | 21 ++
 rtl/hazard_stall_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / stall controller.
// Idle output values are the pass-through state of the pipeline control signals.
package hazard_pkg;

   localparam int unsigned REG_AW_DEF = 5;

   typedef enum logic {
      HZ_IDLE  = 1'b0,
      HZ_STALL = 1'b1
   } hz_state_t;

   localparam logic IDLE_PC_WRITE    = 1'b1;
   localparam logic IDLE_IF_ID_WRITE = 1'b1;
   localparam logic IDLE_IF_ID_FLUSH = 1'b0;
   localparam logic IDLE_CONTROL_SEL = 1'b1;
   localparam logic IDLE_PIPE_HOLD   = 1'b0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall-cycle counter; only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard controller with taken-branch flush and memory-busy freeze.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW   = REG_AW_DEF,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] if_id_rs,
   input  logic [REG_AW-1:0] if_id_rt,
   input  logic [REG_AW-1:0] id_ex_rt,
   input  logic              id_ex_memread,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              control_sel,
   output logic              pipe_hold,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned RC_W = $clog2(LOAD_LAT) + 1;
   localparam logic [RC_W-1:0] LAT_M1 = RC_W'(LOAD_LAT - 1);

   hz_state_t       state, state_next;
   logic [RC_W-1:0] rem_cnt, rem_cnt_next;
   logic            hit;
   logic            stall_act;

   always_comb begin
      hit = id_ex_memread && (id_ex_rt != '0) &&
            ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
      stall_act = !mem_busy && !branch_taken && ((state == HZ_STALL) || hit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HZ_IDLE;
         rem_cnt <= '0;
      end else begin
         state   <= state_next;
         rem_cnt <= rem_cnt_next;
      end
   end

   // The hazard cycle itself counts as the first held cycle, so STALL covers LOAD_LAT-1 more.
   always_comb begin
      state_next   = state;
      rem_cnt_next = rem_cnt;
      if (mem_busy) begin
         state_next   = state;
         rem_cnt_next = rem_cnt;
      end else if (branch_taken) begin
         state_next   = HZ_IDLE;
         rem_cnt_next = '0;
      end else if (state == HZ_STALL) begin
         if (rem_cnt <= RC_W'(1)) begin
            state_next   = HZ_IDLE;
            rem_cnt_next = '0;
         end else begin
            rem_cnt_next = rem_cnt - 1'b1;
         end
      end else if (hit && (LOAD_LAT > 1)) begin
         state_next   = HZ_STALL;
         rem_cnt_next = LAT_M1;
      end
   end

   always_comb begin
      pc_write    = IDLE_PC_WRITE;
      if_id_write = IDLE_IF_ID_WRITE;
      if_id_flush = IDLE_IF_ID_FLUSH;
      control_sel = IDLE_CONTROL_SEL;
      pipe_hold   = IDLE_PIPE_HOLD;
      if (mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
         control_sel = 1'b0;
      end else if (stall_act) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         control_sel = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt #(
      .CNT_W(CNT_W)
   ) u_perf_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (stall_act),
      .count(stall_cycles)
   );
`else
   assign stall_cycles = '0;
`endif

endmodule
